// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin packet bus.
// Pure declarations only; no timing of its own.
// No flow control here; consumers decide how to use the ID field.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } bus_state_e;

    localparam int ID_W      = 8;
    // Widest packet id_of() accepts; callers zero-extend into this width.
    localparam int PKT_MAX_W = 512;

    // Destination ID is the top ID_W bits of a pkt_w-bit packet.
    function automatic logic [ID_W-1:0] id_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int                   pkt_w);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (pkt_w - ID_W);
        return sh[ID_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin pick: first set req bit strictly after ptr, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arbiter_core #(
    parameter int drvrs = 4,
    parameter int IDX_W = $clog2(drvrs)
) (
    input  logic [drvrs-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    // Scan from farthest to nearest so the nearest requester after ptr wins last.
    always_comb begin
        int             idx;
        logic [IDX_W-1:0] idx_v;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        idx_v = '0;
        for (int k = drvrs; k >= 1; k--) begin
            idx   = (int'(ptr) + k) % drvrs;
            idx_v = IDX_W'(idx);
            if (req[idx_v]) begin
                grant = idx_v;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_router.sv
// Shared bus: round-robin pops one head packet per grant and routes it (unicast/broadcast/drop).
// Latency: pndng seen in IDLE -> pop next cycle -> push the cycle after; 1 packet per 2 cycles.
// Backpressure: none on the push side; pndng is the only request. Optional BUS_STATS_EN adds counters.
module bus_rr_router
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
`ifdef BUS_STATS_EN
    ,
    output logic [31:0]                     stat_delivered,
    output logic [15:0]                     stat_dropped
`endif
);

    localparam int IDX_W = $clog2(drvrs);

    bus_state_e         state;
    bus_state_e         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_q;
    logic [IDX_W-1:0]   arb_gnt;
    logic               arb_vld;
    logic [pckg_sz-1:0] pkt_q;
    logic [ID_W-1:0]    dst;
    logic [drvrs-1:0]   push_mask;

    rr_arbiter_core #(
        .drvrs (drvrs),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (pndng),
        .ptr   (rr_ptr),
        .grant (arb_gnt),
        .valid (arb_vld)
    );

    assign dst    = id_of(PKT_MAX_W'(pkt_q), pckg_sz);
    assign D_push = {drvrs{pkt_q}};

    // Destination decode; self-addressed and out-of-range IDs fall through to an empty mask.
    always_comb begin
        push_mask = '0;
        if (dst == broadcast) begin
            push_mask        = '1;
            push_mask[gnt_q] = 1'b0;
        end else if (int'(dst) < drvrs && dst != ID_W'(gnt_q)) begin
            push_mask[dst[IDX_W-1:0]] = 1'b1;
        end
    end

    // Next state and strobes; pop and push live in different states so they never overlap.
    always_comb begin
        state_nxt = state;
        pop       = '0;
        push      = '0;
        case (state)
            IDLE: begin
                if (arb_vld) state_nxt = POP;
            end
            POP: begin
                pop[gnt_q] = 1'b1;
                state_nxt  = PUSH;
            end
            PUSH: begin
                push      = push_mask;
                state_nxt = arb_vld ? POP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant, captured packet and round-robin pointer; a reset discards any in-flight packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= IDX_W'(drvrs - 1);
            gnt_q  <= '0;
            pkt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == POP) gnt_q <= arb_gnt;
            if (state == POP) begin
                pkt_q  <= D_pop[gnt_q];
                rr_ptr <= gnt_q;
            end
        end
    end

`ifdef BUS_STATS_EN
    // Delivered wraps naturally; dropped sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_delivered <= '0;
            stat_dropped   <= '0;
        end else if (state == PUSH) begin
            if (|push_mask)
                stat_delivered <= stat_delivered + 32'd1;
            else if (stat_dropped != 16'hFFFF)
                stat_dropped <= stat_dropped + 16'd1;
        end
    end
`endif

endmodule
